// File: rtl/seg_display_sched_pkg.sv
// Shared types and helpers for the seven-segment display scheduler and its round-robin pickers.
// The round-robin search is written for up to 8 requesters so that other arbiters can reuse it.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        PIN  = 2'd2
    } state_t;

    localparam int DWELL_DEFAULT = 50_000_000;
    localparam int MAX_SRC       = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // First set bit of mask[n-1:0] at or after start, wrapping at n.
    function automatic pick_t next_valid(input logic [7:0] mask,
                                         input logic [2:0] start,
                                         input int         n);
        pick_t r;
        int    j;
        r = '0;
        j = 0;
        for (int k = 0; k < MAX_SRC; k++) begin
            if (k < n && !r.found) begin
                j = int'(start) + k;
                if (j >= n) begin
                    j = j - n;
                end
                if (mask[j[2:0]]) begin
                    r.found = 1'b1;
                    r.idx   = j[2:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_display_sched_if.sv
// Requester and display-side signals of the segment display scheduler.
// master = CPU debug taps / decoder side, slave = the scheduler.
interface seg_display_sched_if #(
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = $clog2(NUM_SRC)
);
    logic [NUM_SRC-1:0]   src_valid;
    logic [8*NUM_SRC-1:0] src_data;
    logic                 pin_req;
    logic [SEL_W-1:0]     pin_sel;
    logic [7:0]           disp_data;
    logic [SEL_W-1:0]     disp_src;
    logic                 disp_valid;
    logic                 slot_tick;

    modport master (
        output src_valid, src_data, pin_req, pin_sel,
        input  disp_data, disp_src, disp_valid, slot_tick
    );

    modport slave (
        input  src_valid, src_data, pin_req, pin_sel,
        output disp_data, disp_src, disp_valid, slot_tick
    );
endinterface

// File: rtl/seg_display_sched_rr_pick.sv
// Round-robin search: first set bit of mask at or after start, with wrap.
// Latency: purely combinational.
// Backpressure: none.
module rr_pick
    import disp_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     mask,
    input  logic [SEL_W-1:0] start,
    output logic [SEL_W-1:0] idx,
    output logic             found
);
    logic [7:0] mask8;
    pick_t      pick;

    always_comb begin
        mask8        = '0;
        mask8[N-1:0] = mask;
        pick         = next_valid(mask8, 3'(start), N);
        idx          = pick.idx[SEL_W-1:0];
        found        = pick.found;
    end
endmodule

// File: rtl/seg_display_sched.sv
// Time-shares the two-digit hex display round-robin between valid byte sources, with pin override.
// Latency: all outputs registered; input change at cycle t is visible at t+1.
// Backpressure: none; the downstream decoder consumes disp_data every cycle.
module seg_display_sched
    import disp_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DWELL   = DWELL_DEFAULT,
    parameter int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic              clk,
    input  logic              rst,
    seg_display_sched_if.slave bus
);
    localparam int                CNT_W  = $clog2(DWELL);
    localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(DWELL - 1);
    localparam logic [SEL_W:0]    NSRC   = (SEL_W + 1)'(NUM_SRC);
    localparam logic [SEL_W-1:0]  LAST   = SEL_W'(NUM_SRC - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] cur_q, cur_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_d;

    logic [7:0]       disp_data_q;
    logic [SEL_W-1:0] disp_src_q;
    logic             disp_valid_q;
    logic             slot_tick_q;

    logic             pin_ok;
    logic [SEL_W-1:0] cur_inc;
    logic [SEL_W-1:0] start_idx, next_idx;
    logic             start_found, next_found;

    assign pin_ok  = bus.pin_req && ({1'b0, bus.pin_sel} < NSRC);
    assign cur_inc = (cur_q == LAST) ? '0 : cur_q + 1'b1;

    // Resume point after IDLE, remembered so a fresh burst does not always favour source 0.
    rr_pick #(.N(NUM_SRC), .SEL_W(SEL_W)) u_pick_start (
        .mask  (bus.src_valid),
        .start (ptr_q),
        .idx   (start_idx),
        .found (start_found)
    );

    // Search starts just past cur, so cur itself is only chosen when it is the sole valid source.
    rr_pick #(.N(NUM_SRC), .SEL_W(SEL_W)) u_pick_next (
        .mask  (bus.src_valid),
        .start (cur_inc),
        .idx   (next_idx),
        .found (next_found)
    );

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pin_ok) begin
                    state_d = PIN;
                    cur_d   = bus.pin_sel;
                end else if (start_found) begin
                    state_d = SHOW;
                    cur_d   = start_idx;
                    cnt_d   = RELOAD;
                end
            end
            SHOW: begin
                if (pin_ok) begin
                    state_d = PIN;
                    cur_d   = bus.pin_sel;
                end else if (cnt_q == '0 || !bus.src_valid[cur_q]) begin
                    // Expiry and mid-slot drop share one path; only expiry pulses the tick.
                    tick_d = (cnt_q == '0);
                    ptr_d  = cur_inc;
                    cnt_d  = RELOAD;
                    if (next_found) begin
                        cur_d = next_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PIN: begin
                if (!bus.pin_req) begin
                    state_d = SHOW;
                    cnt_d   = RELOAD;
                end else if (pin_ok) begin
                    cur_d = bus.pin_sel;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cur_q        <= '0;
            ptr_q        <= '0;
            cnt_q        <= '0;
            disp_data_q  <= 8'h00;
            disp_src_q   <= '0;
            disp_valid_q <= 1'b0;
            slot_tick_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            slot_tick_q  <= tick_d;
            disp_valid_q <= (state_d != IDLE);
            // Registered from the next-state index so the first slot shows one cycle after the request.
            if (state_d != IDLE) begin
                disp_data_q <= bus.src_data[{cur_d, 3'b000} +: 8];
                disp_src_q  <= cur_d;
            end else begin
                disp_data_q <= 8'h00;
                disp_src_q  <= '0;
            end
        end
    end

    assign bus.disp_data  = disp_data_q;
    assign bus.disp_src   = disp_src_q;
    assign bus.disp_valid = disp_valid_q;
    assign bus.slot_tick  = slot_tick_q;

endmodule

// File: tb/tb_seg_display_sched.sv
// Directed bench for seg_display_sched: a 4-source instance and a 6-source instance, DWELL=4.
module tb_seg_display_sched;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    seg_display_sched_if #(.NUM_SRC(4)) bus_a ();
    seg_display_sched_if #(.NUM_SRC(6)) bus_b ();

    seg_display_sched #(.NUM_SRC(4), .DWELL(4)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    seg_display_sched #(.NUM_SRC(6), .DWELL(4)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    // Bytes for the 4-source instance: {D3, C2, B1, A0}.
    function automatic logic [7:0] byte_a(input int s);
        case (s)
            0:       return 8'hA0;
            1:       return 8'hB1;
            2:       return 8'hC2;
            default: return 8'hD3;
        endcase
    endfunction

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.src_valid = 4'b0000;
        bus_a.src_data  = 32'hD3C2_B1A0;
        bus_a.pin_req   = 1'b0;
        bus_a.pin_sel   = 2'd0;
        bus_b.src_valid = 6'b000000;
        bus_b.src_data  = 48'h6554_4332_2110;
        bus_b.pin_req   = 1'b0;
        bus_b.pin_sel   = 3'd0;
        repeat (3) step_cycle();
        checks++;
        if ({bus_a.disp_valid, bus_a.disp_src, bus_a.disp_data, bus_a.slot_tick} !== 12'h000) begin
            errors++;
            $display("FAIL reset_hold got valid=%b src=%0d data=%h tick=%b want 0/0/00/0",
                     bus_a.disp_valid, bus_a.disp_src, bus_a.disp_data, bus_a.slot_tick);
        end
        rst_a = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step_cycle();
            checks++;
            if ({bus_a.disp_valid, bus_a.disp_src, bus_a.disp_data, bus_a.slot_tick} !== 12'h000) begin
                errors++;
                $display("FAIL idle_empty cyc=%0d got valid=%b src=%0d data=%h tick=%b want 0/0/00/0",
                         i, bus_a.disp_valid, bus_a.disp_src, bus_a.disp_data, bus_a.slot_tick);
            end
        end
    endtask

    task automatic test_rotation();
        int         exp_src;
        logic       exp_tick;
        bus_a.src_valid = 4'b1011;
        for (int i = 1; i <= 13; i++) begin
            step_cycle();
            exp_src  = (i <= 4) ? 0 : (i <= 8) ? 1 : (i <= 12) ? 3 : 0;
            exp_tick = (i == 5 || i == 9 || i == 13);
            checks++;
            if ({bus_a.disp_valid, bus_a.disp_src, bus_a.disp_data, bus_a.slot_tick}
                !== {1'b1, 2'(exp_src), byte_a(exp_src), exp_tick}) begin
                errors++;
                $display("FAIL rotate cyc=%0d got valid=%b src=%0d data=%h tick=%b want 1/%0d/%h/%b",
                         i, bus_a.disp_valid, bus_a.disp_src, bus_a.disp_data, bus_a.slot_tick,
                         exp_src, byte_a(exp_src), exp_tick);
            end
        end
    endtask

    task automatic test_drop();
        int n;
        n = 0;
        step_cycle();
        while (!(bus_a.disp_src == 2'd1 && bus_a.slot_tick) && n < 20) begin
            step_cycle();
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL drop_wait got no tick into source 1 within 20 cycles");
        end
        step_cycle();
        checks++;
        if ({bus_a.disp_src, bus_a.slot_tick} !== {2'd1, 1'b0}) begin
            errors++;
            $display("FAIL drop_second got src=%0d tick=%b want 1/0", bus_a.disp_src, bus_a.slot_tick);
        end
        bus_a.src_valid = 4'b1001;
        for (int i = 1; i <= 4; i++) begin
            step_cycle();
            checks++;
            if ({bus_a.disp_valid, bus_a.disp_src, bus_a.disp_data, bus_a.slot_tick}
                !== {1'b1, 2'd3, 8'hD3, 1'b0}) begin
                errors++;
                $display("FAIL drop_slot cyc=%0d got valid=%b src=%0d data=%h tick=%b want 1/3/d3/0",
                         i, bus_a.disp_valid, bus_a.disp_src, bus_a.disp_data, bus_a.slot_tick);
            end
        end
        step_cycle();
        checks++;
        if ({bus_a.disp_src, bus_a.disp_data, bus_a.slot_tick} !== {2'd0, 8'hA0, 1'b1}) begin
            errors++;
            $display("FAIL drop_expiry got src=%0d data=%h tick=%b want 0/a0/1",
                     bus_a.disp_src, bus_a.disp_data, bus_a.slot_tick);
        end
    endtask

    task automatic test_pin();
        bus_a.pin_sel = 2'd2;
        bus_a.pin_req = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step_cycle();
            checks++;
            if ({bus_a.disp_valid, bus_a.disp_src, bus_a.disp_data, bus_a.slot_tick}
                !== {1'b1, 2'd2, 8'hC2, 1'b0}) begin
                errors++;
                $display("FAIL pin_hold cyc=%0d got valid=%b src=%0d data=%h tick=%b want 1/2/c2/0",
                         i, bus_a.disp_valid, bus_a.disp_src, bus_a.disp_data, bus_a.slot_tick);
            end
        end
        bus_a.pin_req = 1'b0;
        step_cycle();
        checks++;
        if ({bus_a.disp_src, bus_a.slot_tick} !== {2'd2, 1'b0}) begin
            errors++;
            $display("FAIL pin_release got src=%0d tick=%b want 2/0", bus_a.disp_src, bus_a.slot_tick);
        end
        step_cycle();
        checks++;
        if ({bus_a.disp_src, bus_a.disp_data, bus_a.slot_tick} !== {2'd3, 8'hD3, 1'b0}) begin
            errors++;
            $display("FAIL pin_advance got src=%0d data=%h tick=%b want 3/d3/0",
                     bus_a.disp_src, bus_a.disp_data, bus_a.slot_tick);
        end
    endtask

    task automatic test_reset_mid_slot();
        int n;
        bus_a.src_valid = 4'b1011;
        n = 0;
        step_cycle();
        while (!(bus_a.disp_src == 2'd1 && bus_a.slot_tick) && n < 30) begin
            step_cycle();
            n++;
        end
        checks++;
        if (n >= 30) begin
            errors++;
            $display("FAIL rst_wait got no tick into source 1 within 30 cycles");
        end
        step_cycle();
        rst_a = 1'b1;
        step_cycle();
        checks++;
        if ({bus_a.disp_valid, bus_a.disp_src, bus_a.disp_data, bus_a.slot_tick} !== 12'h000) begin
            errors++;
            $display("FAIL rst_mid got valid=%b src=%0d data=%h tick=%b want 0/0/00/0",
                     bus_a.disp_valid, bus_a.disp_src, bus_a.disp_data, bus_a.slot_tick);
        end
        rst_a = 1'b0;
        step_cycle();
        checks++;
        if ({bus_a.disp_valid, bus_a.disp_src, bus_a.disp_data, bus_a.slot_tick}
            !== {1'b1, 2'd0, 8'hA0, 1'b0}) begin
            errors++;
            $display("FAIL rst_restart got valid=%b src=%0d data=%h tick=%b want 1/0/a0/0",
                     bus_a.disp_valid, bus_a.disp_src, bus_a.disp_data, bus_a.slot_tick);
        end
    endtask

    task automatic test_pin_range();
        int   exp_src;
        logic exp_tick;
        bus_b.src_valid = 6'b001111;
        bus_b.pin_sel   = 3'd7;
        bus_b.pin_req   = 1'b1;
        rst_b = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            step_cycle();
            exp_src  = (i <= 4) ? 0 : (i <= 8) ? 1 : (i <= 12) ? 2 : (i <= 16) ? 3 : 0;
            exp_tick = (i == 5 || i == 9 || i == 13 || i == 17);
            checks++;
            if ({bus_b.disp_valid, bus_b.disp_src, bus_b.disp_data, bus_b.slot_tick}
                !== {1'b1, 3'(exp_src), 4'(exp_src + 1), 4'(exp_src), exp_tick}) begin
                errors++;
                $display("FAIL pin_range cyc=%0d got valid=%b src=%0d data=%h tick=%b want 1/%0d/%h%h/%b",
                         i, bus_b.disp_valid, bus_b.disp_src, bus_b.disp_data, bus_b.slot_tick,
                         exp_src, 4'(exp_src + 1), 4'(exp_src), exp_tick);
            end
        end
        bus_b.pin_sel = 3'd5;
        step_cycle();
        checks++;
        if ({bus_b.disp_src, bus_b.disp_data, bus_b.slot_tick} !== {3'd5, 8'h65, 1'b0}) begin
            errors++;
            $display("FAIL pin_five got src=%0d data=%h tick=%b want 5/65/0",
                     bus_b.disp_src, bus_b.disp_data, bus_b.slot_tick);
        end
        for (int i = 1; i <= 4; i++) begin
            bus_b.pin_sel = (i == 4) ? 3'd6 : 3'd7;
            step_cycle();
            checks++;
            if ({bus_b.disp_valid, bus_b.disp_src, bus_b.slot_tick} !== {1'b1, 3'd5, 1'b0}) begin
                errors++;
                $display("FAIL pin_keep cyc=%0d got valid=%b src=%0d tick=%b want 1/5/0",
                         i, bus_b.disp_valid, bus_b.disp_src, bus_b.slot_tick);
            end
        end
        bus_b.pin_req = 1'b0;
        step_cycle();
        step_cycle();
        checks++;
        if ({bus_b.disp_src, bus_b.disp_data, bus_b.slot_tick} !== {3'd0, 8'h10, 1'b0}) begin
            errors++;
            $display("FAIL pin_wrap got src=%0d data=%h tick=%b want 0/10/0",
                     bus_b.disp_src, bus_b.disp_data, bus_b.slot_tick);
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_drop();
        test_pin();
        test_reset_mid_slot();
        test_pin_range();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_display_sched.md
# seg_display_sched

Time-shares the two-digit hex seven-segment display between up to NUM_SRC byte-wide requesters (PC, ALU result, memory data, debug register, ...). It sits between the CPU debug taps and the hex-to-segment decoder. It rotates round-robin over the sources that are currently valid, holding each for a programmable dwell time. A pin request can freeze the display on one chosen source. Segment encoding is not done here: disp_data feeds the downstream decoder (low nibble to digit 1, high nibble to digit 2).

## Interface
- NUM_SRC, 4: number of requesters, 2..8.
- DWELL, 50_000_000: cycles per display slot, must be ≥ 2.
- SEL_W, $clog2(NUM_SRC): width of source index (derived).

- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- src_valid  in  NUM_SRC  bit i high = source i wants display time.
- src_data  in  8*NUM_SRC  byte of source i at [8i+7:8i].
- pin_req  in  1  level; hold display on pin_sel while high.
- pin_sel  in  SEL_W  source to pin.
- disp_data  out  8  byte to the segment decoder.
- disp_src  out  SEL_W  index currently shown.
- disp_valid  out  1  disp_data is meaningful (decoder blanks otherwise).
- slot_tick  out  1  one-cycle pulse at each dwell expiry.

## Operation
- Reset: state IDLE, disp_data=8'h00, disp_src=0, disp_valid=0, slot_tick=0, counter=0, pointer=0.
- States: IDLE, SHOW, PIN.
- IDLE: if pin_req and pin_sel<NUM_SRC → PIN. Else if any src_valid → SHOW, cur = first valid index searching upward from pointer with wrap, counter=DWELL-1. Otherwise stay. Outputs hold their reset values.
- SHOW, every cycle: disp_data ← src_data[cur], disp_src ← cur, disp_valid ← 1. The data is live, so a changing source updates the display.
- SHOW, counter>0 and src_valid[cur]=1: counter decrements.
- SHOW, counter==0: slot_tick=1 for one cycle. cur = next valid index after cur (wrap). If none other is valid but cur is, cur stays. Counter reloads to DWELL-1.
- SHOW, src_valid[cur] drops mid-slot: advance next cycle exactly as at expiry, but without slot_tick. If no source is valid → IDLE and disp_valid=0.
- Pin: pin_req=1 with pin_sel<NUM_SRC wins over all other SHOW/IDLE transitions → PIN.
- PIN: cur=pin_sel, tracked each cycle. The pinned source is shown regardless of its src_valid. Counter frozen, no slot_tick.
- PIN, pin_sel ≥ NUM_SRC: request ignored. In PIN, such a value leaves cur unchanged.
- PIN, pin_req falls: → SHOW with cur unchanged and counter reloaded to DWELL-1. If the pinned source is not valid, SHOW advances the following cycle per the drop rule.
- Pointer: updated to cur+1 (mod NUM_SRC) whenever SHOW leaves a source, which gives fairness after IDLE.
- Simultaneous expiry and drop of cur: treated as expiry (slot_tick=1).
- rst mid-slot or mid-pin: next cycle equals the reset state.

## Timing
- All outputs registered.
- Latency: src_data change at cycle t appears on disp_data at t+1.
- IDLE → first valid at cycle t: disp_valid=1 at t+1.
- Slot length: exactly DWELL cycles between consecutive slot_tick pulses while cur stays valid and no pin occurs.
- Pin: pin_req rising at cycle t: disp_src=pin_sel at t+1.
- No combinational path from inputs to outputs.

## Structure
- Shared package disp_pkg:
  - state enum {IDLE, SHOW, PIN}.
  - DWELL default constant.
  - function next_valid(mask, start) returning the first set index at or after start with wrap, plus a found flag.
- One sub-module is natural: rr_pick (combinational round-robin search over NUM_SRC bits), reusable by other arbiters.
- Counter width: $clog2(DWELL).

## Test plan
Bench uses NUM_SRC=4, DWELL=4.
- Reset, then src_valid=4'b0000 for 10 cycles → disp_valid=0, disp_data=8'h00, slot_tick never high.
- src_valid=4'b1011, data {8'hD3,8'hC2,8'hB1,8'hA0} → disp_src sequence 0,1,3,0 with each slot 4 cycles long. slot_tick at each change, disp_data A0,B1,D3,A0.
- Source 1 showing, drop src_valid[1] at its 2nd cycle → disp_src=3 on the next cycle, no slot_tick, full 4-cycle slot for 3.
- pin_req=1, pin_sel=2 with src_valid[2]=0 for 12 cycles → disp_src=2 throughout, no slot_tick. After release, one cycle shows 2, then the scheduler advances to 3.
- pin_sel=3'd5 (out of range, NUM_SRC=4 requires SEL_W widened by the bench via NUM_SRC=6 variant with only 4 sources valid): pin with pin_sel=7 → ignored, rotation continues.
- Assert rst mid-slot with counter=2 → next cycle all outputs at reset values, and rotation restarts from source 0.
